// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration loader and the generator it drives.
// Reset defaults here must match the generator's own reset values.
package pwm_cfg_pkg;

    localparam int PWM_DATA_W         = 16;
    localparam int PWM_PERIOD_RESET   = 124;
    localparam int PWM_DUTY_RESET     = 62;
    localparam int PWM_WR_HIGH_CYCLES = 2;
    localparam int WR_CNT_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_WRP  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DUTY = 3'd4
    } state_t;

endpackage

// File: rtl/pwm_cfg_loader.sv
// Sequences {period, duty} updates into the PWM generator, aligning every write
// to a period boundary signalled by the generator's event count output.
module pwm_cfg_loader
    import pwm_cfg_pkg::*;
#(
    parameter int DATA_W         = PWM_DATA_W,
    parameter int PERIOD_RESET   = PWM_PERIOD_RESET,
    parameter int DUTY_RESET     = PWM_DUTY_RESET,
    parameter int WR_HIGH_CYCLES = PWM_WR_HIGH_CYCLES
) (
    input  logic              refClock,
    input  logic              nReset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [DATA_W-1:0] cmdPeriod,
    input  logic [DATA_W-1:0] cmdDuty,
    input  logic              cmdDutyOnly,
    input  logic              evtCnt,
    output logic [DATA_W-1:0] data,
    output logic              enDC,
    output logic              writePeriod,
    output logic              busy,
    output logic              done,
    output logic              clamped
);

    localparam logic [WR_CNT_W-1:0] WR_LAST = WR_CNT_W'(WR_HIGH_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [WR_CNT_W-1:0] r_wr_cnt;

    logic [DATA_W-1:0]   r_cur_period;
    logic [DATA_W-1:0]   r_cur_duty;
    logic [DATA_W-1:0]   r_pend_period;
    logic [DATA_W-1:0]   r_pend_duty;
    logic                r_clamp;

    logic                w_accept;
    logic                w_commit;
    logic [DATA_W-1:0]   w_eff_period;
    logic                w_clamp;
    logic [DATA_W-1:0]   w_cur_period_next;
    logic [DATA_W-1:0]   w_cur_duty_next;
    logic [DATA_W-1:0]   w_pend_period_next;
    logic [DATA_W-1:0]   w_pend_duty_next;
    logic                w_clamp_next;

    logic [DATA_W-1:0]   w_data_next;
    logic                w_endc_next;
    logic                w_wp_next;
    logic                w_ready_next;
    logic                w_busy_next;
    logic                w_done_next;
    logic                w_clamped_next;

    assign w_accept = (r_state == ST_IDLE) && cmdValid;
    assign w_commit = (r_state == ST_DUTY) && evtCnt;

    // Clamp is evaluated against the period that will be in force when the duty lands.
    assign w_eff_period = cmdDutyOnly ? r_cur_period : cmdPeriod;
    assign w_clamp      = cmdDuty > w_eff_period;

    assign w_pend_period_next = w_accept ? cmdPeriod : r_pend_period;
    assign w_pend_duty_next   = w_accept ? (w_clamp ? w_eff_period : cmdDuty) : r_pend_duty;
    assign w_clamp_next       = w_accept ? w_clamp : r_clamp;
    assign w_cur_period_next  = (r_state == ST_HOLD) ? r_pend_period : r_cur_period;
    assign w_cur_duty_next    = w_commit ? r_pend_duty : r_cur_duty;

    always_ff @(posedge refClock or negedge nReset) begin
        if (!nReset) begin
            r_state       <= ST_IDLE;
            r_wr_cnt      <= '0;
            r_cur_period  <= DATA_W'(PERIOD_RESET);
            r_cur_duty    <= DATA_W'(DUTY_RESET);
            r_pend_period <= '0;
            r_pend_duty   <= '0;
            r_clamp       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wr_cnt      <= (r_state == ST_WRP) ? r_wr_cnt + WR_CNT_W'(1) : '0;
            r_cur_period  <= w_cur_period_next;
            r_cur_duty    <= w_cur_duty_next;
            r_pend_period <= w_pend_period_next;
            r_pend_duty   <= w_pend_duty_next;
            r_clamp       <= w_clamp_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (cmdValid) w_state_next = cmdDutyOnly ? ST_DUTY : ST_SYNC;
            ST_SYNC: if (evtCnt) w_state_next = ST_WRP;
            ST_WRP:  if (r_wr_cnt == WR_LAST) w_state_next = ST_HOLD;
            ST_HOLD: w_state_next = ST_DUTY;
            ST_DUTY: if (evtCnt) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without lag.
    always_comb begin
        w_data_next    = w_cur_duty_next;
        w_endc_next    = 1'b0;
        w_wp_next      = 1'b0;
        w_ready_next   = 1'b0;
        w_busy_next    = (w_state_next != ST_IDLE);
        w_done_next    = w_commit;
        w_clamped_next = w_commit && r_clamp;
        case (w_state_next)
            ST_IDLE: w_ready_next = 1'b1;
            ST_SYNC: w_data_next  = w_cur_duty_next;
            ST_WRP: begin
                w_data_next = w_pend_period_next;
                w_endc_next = 1'b1;
                w_wp_next   = 1'b1;
            end
            ST_HOLD: begin
                w_data_next = w_pend_period_next;
                w_endc_next = 1'b1;
            end
            ST_DUTY: w_data_next = w_pend_duty_next;
            default: w_data_next = w_cur_duty_next;
        endcase
    end

    always_ff @(posedge refClock or negedge nReset) begin
        if (!nReset) begin
            data        <= DATA_W'(DUTY_RESET);
            enDC        <= 1'b0;
            writePeriod <= 1'b0;
            cmdReady    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            clamped     <= 1'b0;
        end else begin
            data        <= w_data_next;
            enDC        <= w_endc_next;
            writePeriod <= w_wp_next;
            cmdReady    <= w_ready_next;
            busy        <= w_busy_next;
            done        <= w_done_next;
            clamped     <= w_clamped_next;
        end
    end

endmodule

// File: tb/tb_pwm_cfg_loader.sv
// Directed bench for pwm_cfg_loader with queue-based scoreboard on period writes and done pulses.
module tb_pwm_cfg_loader;

    localparam int DW = 16;
    localparam int WR = 2;

    logic          refClock = 1'b0;
    logic          nReset   = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [DW-1:0] cmdPeriod = '0;
    logic [DW-1:0] cmdDuty   = '0;
    logic          cmdDutyOnly = 1'b0;
    logic          evtCnt = 1'b0;
    logic [DW-1:0] data;
    logic          enDC, writePeriod, busy, done, clamped;

    pwm_cfg_loader dut (
        .refClock(refClock), .nReset(nReset), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdPeriod(cmdPeriod), .cmdDuty(cmdDuty), .cmdDutyOnly(cmdDutyOnly), .evtCnt(evtCnt),
        .data(data), .enDC(enDC), .writePeriod(writePeriod), .busy(busy), .done(done),
        .clamped(clamped)
    );

    always #5 refClock = ~refClock;

    typedef struct { int clamp; int duty; } exp_done_t;
    int        exp_wr[$];
    exp_done_t exp_done[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int evt_ctr  = 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d @%0t", name, act, $time);
        end
    endtask

    // One clock per call; generator event is high for one cycle every 125.
    task automatic tick();
        @(negedge refClock);
        evt_ctr = (evt_ctr + 1) % 125;
        evtCnt  = (evt_ctr == 0);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int k = 0; k < budget && done_seen < target; k++) tick();
        check("done_within_budget", int'(done_seen >= target), 1);
    endtask

    // Monitor: one write transaction per enDC run, one done transaction per pulse.
    int en_run = 0, wp_run = 0, wr_val = 0, wr_stable = 1;
    always @(posedge refClock) begin
        #1;
        if (!nReset) begin
            en_run = 0; wp_run = 0; wr_stable = 1;
        end else begin
            if (enDC) begin
                if (en_run == 0) wr_val = int'(data);
                else if (int'(data) != wr_val) wr_stable = 0;
                en_run++;
                if (writePeriod) wp_run++;
            end else if (en_run != 0) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_period_write", 1, 0);
                end else begin
                    check("wr_period_value", wr_val, exp_wr.pop_front());
                    check("wr_high_cycles", wp_run, WR);
                    check("endc_cycles", en_run, WR + 1);
                    check("wr_data_stable", wr_stable, 1);
                end
                en_run = 0; wp_run = 0; wr_stable = 1;
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_done_t e;
                    e = exp_done.pop_front();
                    check("done_clamped", int'(clamped), e.clamp);
                    check("done_new_duty", int'(data), e.duty);
                    check("done_ready", int'(cmdReady), 1);
                end
            end
        end
    end

    initial begin : main
        int base;
        int k;

        // Reset
        repeat (3) tick();
        nReset = 1'b1;
        repeat (2) tick();
        check("rst_data", int'(data), 62);
        check("rst_endc", int'(enDC), 0);
        check("rst_wp", int'(writePeriod), 0);
        check("rst_ready", int'(cmdReady), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // Full update 200/50
        evt_ctr = 115;
        exp_wr.push_back(200);
        exp_done.push_back('{clamp: 0, duty: 50});
        cmdValid = 1'b1; cmdPeriod = 200; cmdDuty = 50; cmdDutyOnly = 1'b0;
        tick();
        cmdValid = 1'b0;
        check("full_ready_drop", int'(cmdReady), 0);
        check("full_busy", int'(busy), 1);
        check("full_sync_data", int'(data), 62);
        wait_done(1, 400);

        // Duty-only 300 against period 200 -> clamp
        exp_done.push_back('{clamp: 1, duty: 200});
        cmdValid = 1'b1; cmdPeriod = 999; cmdDuty = 300; cmdDutyOnly = 1'b1;
        tick();
        cmdValid = 1'b0;
        check("donly_data", int'(data), 200);
        check("donly_endc", int'(enDC), 0);
        wait_done(2, 400);
        repeat (3) tick();
        check("donly_idle_data", int'(data), 200);

        // Back-to-back: second command held valid while busy
        base = done_seen;
        exp_wr.push_back(100);
        exp_done.push_back('{clamp: 0, duty: 30});
        exp_done.push_back('{clamp: 1, duty: 100});
        cmdValid = 1'b1; cmdPeriod = 100; cmdDuty = 30; cmdDutyOnly = 1'b0;
        tick();
        cmdPeriod = 0; cmdDuty = 150; cmdDutyOnly = 1'b1;
        for (k = 0; k < 400 && !cmdReady; k++) tick();
        check("b2b_ready_with_done", int'(done), 1);
        check("b2b_first_seen", done_seen, base + 1);
        tick();
        cmdValid = 1'b0;
        check("b2b_second_accepted", int'(busy), 1);
        wait_done(base + 2, 400);
        repeat (10) tick();
        check("b2b_two_dones", done_seen, base + 2);

        // Reset during writePeriod high phase
        base = done_seen;
        cmdValid = 1'b1; cmdPeriod = 400; cmdDuty = 10; cmdDutyOnly = 1'b0;
        tick();
        cmdValid = 1'b0;
        for (k = 0; k < 300 && !writePeriod; k++) tick();
        check("mid_wp_reached", int'(writePeriod), 1);
        nReset = 1'b0;
        #1;
        check("mid_rst_wp", int'(writePeriod), 0);
        check("mid_rst_endc", int'(enDC), 0);
        check("mid_rst_data", int'(data), 62);
        check("mid_rst_ready", int'(cmdReady), 1);
        repeat (2) tick();
        nReset = 1'b1;
        repeat (300) tick();
        check("mid_rst_no_done", done_seen, base);
        check("mid_rst_idle_data", int'(data), 62);

        // evtCnt high on the accept edge is ignored
        exp_wr.push_back(80);
        exp_done.push_back('{clamp: 0, duty: 20});
        cmdValid = 1'b1; cmdPeriod = 80; cmdDuty = 20; cmdDutyOnly = 1'b0;
        evt_ctr = 0; evtCnt = 1'b1;
        k = 0;
        do begin
            tick();
            cmdValid = 1'b0;
            k++;
        end while (!writePeriod && k < 300);
        check("accept_edge_evt_delay", k, 126);
        wait_done(base + 1, 400);

        repeat (5) tick();
        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_done_drained", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_cfg_loader.md
# pwm_cfg_loader

Command-driven configuration sequencer placed directly upstream of the PWM generator. Accepts a {period, duty} update over a valid/ready handshake and produces the generator's `data`, `enDC` and `writePeriod` drive. Every update is aligned to a PWM period boundary, taken from the generator's `outEventCnt`. Keeps the current duty on `data` while idle, so the generator re-latches it at each period start.

## Interface
- `DATA_W`, 16: width of period/duty words.
- `PERIOD_RESET`, 124: period value assumed in the generator after reset.
- `DUTY_RESET`, 62: duty held on `data` after reset.
- `WR_HIGH_CYCLES`, 2: cycles `writePeriod` is held high; legal range 2..7.

Ports:
- `refClock` in 1: sole clock.
- `nReset` in 1: asynchronous, active-low reset.
- `cmdValid` in 1: command request.
- `cmdReady` out 1: high only in IDLE.
- `cmdPeriod` in DATA_W: new period; ignored when `cmdDutyOnly`=1.
- `cmdDuty` in DATA_W: new duty.
- `cmdDutyOnly` in 1: update duty only; skip the period write.
- `evtCnt` in 1: generator `outEventCnt`; high while its period counter is 0.
- `data` out DATA_W: to generator `data`.
- `enDC` out 1: to generator `enDC`; 1 means `data` carries the period.
- `writePeriod` out 1: to generator `writePeriod`; the generator detects its rising edge.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse when an update completes.
- `clamped` out 1: valid with `done`; set when the requested duty exceeded the period.

## Operation
- Registers:
  - `curPeriod`: reset value PERIOD_RESET.
  - `curDuty`: reset value DUTY_RESET.
  - `pendPeriod`, `pendDuty`, `pendDutyOnly`, `clampReg`.
- Accept occurs when `cmdValid && cmdReady`. Capture all `cmd*` fields. Compute the clamp against the effective period (`cmdPeriod`, or `curPeriod` when duty-only): if duty > period, store duty = period and set `clampReg`.
- States and transitions:
  - IDLE: `data`=`curDuty`, `enDC`=0, `writePeriod`=0, `cmdReady`=1. On accept, go to DUTY if duty-only, otherwise to SYNC.
  - SYNC: outputs as IDLE, `cmdReady`=0. Move to WRP on the first edge where `evtCnt`=1.
  - WRP: `data`=`pendPeriod`, `enDC`=1, `writePeriod`=1 for exactly WR_HIGH_CYCLES cycles, then go to HOLD.
  - HOLD: `data`=`pendPeriod`, `enDC`=1, `writePeriod`=0, for 1 cycle. At exit, `curPeriod` <= `pendPeriod`. Go to DUTY.
  - DUTY: `data`=`pendDuty`, `enDC`=0. On the first edge with `evtCnt`=1: `curDuty` <= `pendDuty`, `done`=1 and `clamped`=`clampReg` for one cycle, go to IDLE.
- Commands arriving while busy are not accepted; `cmdValid` must stay asserted until accepted.
- Period 0 is legal and passed through unchanged. Duty 0 is passed through without clamping.
- Asserting `nReset` mid-sequence returns all registers and outputs to reset values immediately. The interrupted command is discarded and no `done` is issued.

## Timing
- Reset values of outputs:
  - `data`=DUTY_RESET.
  - `enDC`, `writePeriod`, `busy`, `done`, `clamped` = 0.
  - `cmdReady`=1.
- All outputs are registered and change only on rising `refClock`.
- Full update, accept at edge A:
  - SYNC from A+1.
  - `evtCnt` sampled high at edge E → WRP at E+1..E+WR_HIGH_CYCLES.
  - HOLD for one cycle.
  - DUTY begins; `done` is asserted the cycle after the first `evtCnt` seen in DUTY.
- `enDC`/`data` are stable from the `writePeriod` rise through HOLD, i.e. WR_HIGH_CYCLES+1 cycles, which covers the generator's 2-stage edge detector.
- Duty-only: DUTY from A+1; `done` latency is 1 cycle plus the wait for `evtCnt`.
- If `evtCnt`=1 on the accept edge itself, it is not counted; the next sampled high is used.
- `cmdReady` drops in the cycle after accept and rises together with `done`.

## Structure
- Shared package `pwm_cfg_pkg` holds:
  - the state enum (IDLE, SYNC, WRP, HOLD, DUTY);
  - DATA_W default;
  - PERIOD_RESET/DUTY_RESET defaults, shared with the generator;
  - the WR_HIGH_CYCLES counter width (3 bits).
- Single module; no sub-module. The FSM, the write-pulse counter and the clamp comparator are all inline.

## Test plan
- Reset: after releasing `nReset`, `data`=62, `enDC`=0, `writePeriod`=0, `cmdReady`=1; no `done` is issued.
- Full update {period 200, duty 50}, `evtCnt` pulsing every 125 cycles: `writePeriod` is high for exactly 2 cycles after the first `evtCnt`, with `enDC`=1 and `data`=200 for 3 cycles. Then `data`=50, `enDC`=0, and `done` pulses one cycle after the next `evtCnt` with `clamped`=0.
- Duty-only {duty 300} with `curPeriod`=200: `enDC` never rises; `done` is issued with `clamped`=1, and `data` stays at 200 in IDLE.
- Back-to-back: `cmdValid` held high with a second command while busy → the second command is accepted only in the cycle after the first `done`, and exactly two `done` pulses occur.
- Reset mid-WRP: asserting `nReset` during the `writePeriod` high phase drives `writePeriod`/`enDC` to 0 immediately, `data` returns to 62, and no `done` follows.
- With `evtCnt` high on the accept edge, the period write does not start until the next `evtCnt` assertion.
